// File: rtl/reg_arb_pkg.sv
// Shared types and helpers for the round-robin register-sharing arbiter.
// Holds the FSM state encoding and the index-width rule used by the top and the picker.
package reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Index width for n requesters; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping.
// A lone requester equal to ptr still wins because the search ends back at ptr.
module rr_picker
  import reg_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDXW = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [IDXW-1:0] winner,
  output logic            valid
);

  logic [IDXW-1:0] idx;

  // Scan from the farthest offset down so the nearest requester after ptr is written last.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first; otherwise a latch is inferred.
    winner = ptr;
    valid  = 1'b0;
    idx    = '0;
    for (int off = NREQ; off >= 1; off--) begin
      idx = IDXW'((int'(ptr) + off) % NREQ);
      if (req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter sharing one W-bit register among NREQ requesters.
// Each winner gets a 2-cycle grant, its lane is loaded on the 2nd edge with a 1-cycle ack.
module reg_share_arbiter
  import reg_arb_pkg::*;
#(
  parameter  int           NREQ     = 4,
  parameter  int           W        = 8,
  parameter  int           HOLD_CYC = 1,
  parameter  logic [W-1:0] RST_VAL  = '0,
  localparam int           IDXW     = idx_w(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] wdata,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   ack,
  output logic [W-1:0]      q,
  output logic [IDXW-1:0]   owner,
  output logic              busy
);

  state_t          state, state_d;
  logic [NREQ-1:0] grant_d, ack_d;
  logic [W-1:0]    q_d;
  logic [IDXW-1:0] owner_d, winner;
  logic [7:0]      cnt, cnt_d;
  logic            win_valid;

  // The last winner doubles as the round-robin pointer: search starts just after it.
  rr_picker #(.NREQ(NREQ)) u_picker (
    .req    (req),
    .ptr    (owner),
    .winner (winner),
    .valid  (win_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      ack   <= '0;
      q     <= RST_VAL;
      owner <= IDXW'(NREQ - 1);
      cnt   <= '0;
    end else begin
      // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
      state <= state_d;
      grant <= grant_d;
      ack   <= ack_d;
      q     <= q_d;
      owner <= owner_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    grant_d = grant;
    ack_d   = '0;
    q_d     = q;
    owner_d = owner;
    cnt_d   = cnt;
    unique case (state)
      IDLE: begin
        if (win_valid) begin
          grant_d = {{(NREQ-1){1'b0}}, 1'b1} << winner;
          owner_d = winner;
          state_d = GRANT;
        end
      end
      // req is deliberately ignored here: a selected write always completes.
      GRANT: begin
        q_d     = wdata[int'(owner)*W +: W];
        ack_d   = grant;
        state_d = ACK;
      end
      ACK: begin
        grant_d = '0;
        if (HOLD_CYC > 0) begin
          cnt_d   = 8'(HOLD_CYC - 1);
          state_d = HOLD;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        grant_d = '0;
        if (cnt == 8'd0) state_d = IDLE;
        else             cnt_d   = cnt - 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Self-checking bench for reg_share_arbiter: directed scenarios plus random traffic
// checked against a transaction-age reference model; a second instance has HOLD_CYC=0.
module tb_reg_share_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int HOLD = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, grant, ack;
  logic [31:0] wdata;
  logic [7:0]  q;
  logic [1:0]  owner;
  logic        busy;

  logic [3:0]  req_z, grant_z, ack_z;
  logic [31:0] wdata_z;
  logic [7:0]  q_z;
  logic [1:0]  owner_z;
  logic        busy_z;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: age of the current transaction in cycles (0 = no transaction).
  int         m_age   = 0;
  int         m_owner = NREQ - 1;
  logic [7:0] m_q     = 8'h00;

  always #5 clk = ~clk;

  reg_share_arbiter #(.NREQ(NREQ), .W(W), .HOLD_CYC(HOLD), .RST_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata),
    .grant(grant), .ack(ack), .q(q), .owner(owner), .busy(busy)
  );

  reg_share_arbiter #(.NREQ(NREQ), .W(W), .HOLD_CYC(0), .RST_VAL(8'h00)) dut0 (
    .clk(clk), .rst(rst), .req(req_z), .wdata(wdata_z),
    .grant(grant_z), .ack(ack_z), .q(q_z), .owner(owner_z), .busy(busy_z)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int ptr);
    for (int off = 1; off <= NREQ; off++)
      if (r[(ptr + off) % NREQ]) return (ptr + off) % NREQ;
    return -1;
  endfunction

  task automatic model_reset();
    m_age   = 0;
    m_owner = NREQ - 1;
    m_q     = 8'h00;
  endtask

  task automatic model_edge();
    int w;
    if (m_age == 0) begin
      w = pick(req, m_owner);
      if (w >= 0) begin
        m_owner = w;
        m_age   = 1;
      end
    end else if (m_age == 1) begin
      m_q   = wdata[m_owner*W +: W];
      m_age = 2;
    end else begin
      m_age++;
      if (m_age >= 3 + HOLD) m_age = 0;
    end
  endtask

  task automatic step();
    if (!rst) model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    logic [3:0] oh;
    oh = 4'(1 << m_owner);
    check({tag, ".grant"}, 32'(grant), (m_age == 1 || m_age == 2) ? 32'(oh) : 32'h0);
    check({tag, ".ack"},   32'(ack),   (m_age == 2) ? 32'(oh) : 32'h0);
    check({tag, ".q"},     32'(q),     32'(m_q));
    check({tag, ".owner"}, 32'(owner), 32'(m_owner));
    check({tag, ".busy"},  32'(busy),  32'(m_age != 0));
  endtask

  function automatic int onehot_idx(input logic [3:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial begin
    int order8[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int order2[2] = '{0, 3};
    int n_ack, last_rise, t;
    logic [3:0] prev_grant;
    logic [7:0] qz_exp;

    rst = 1'b1; req = '0; wdata = '0; req_z = '0; wdata_z = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_all("reset");
    check("reset.owner_const", 32'(owner), 32'd3);

    // Single requester, lane0 = 0xA5.
    wdata[7:0] = 8'hA5;
    req = 4'b0001;
    step(); check_all("single.c1"); check("single.grant1", 32'(grant), 32'h1);
    step(); check_all("single.c2"); check("single.q", 32'(q), 32'hA5);
    check("single.ack", 32'(ack), 32'h1); check("single.grant2", 32'(grant), 32'h1);
    req = '0;
    step(); check_all("single.c3"); check("single.hold_busy", 32'(busy), 32'h1);
    step(); check_all("single.c4"); check("single.idle", 32'(busy), 32'h0);

    // Reset asserted mid-transfer: immediate return to reset values, no ack.
    wdata[23:16] = 8'h77;
    req = 4'b0100;
    step(); check_all("midrst.grant");
    rst = 1'b1;
    #1;
    model_reset();
    check("midrst.q", 32'(q), 32'h0);
    check("midrst.grant", 32'(grant), 32'h0);
    check("midrst.ack", 32'(ack), 32'h0);
    check("midrst.busy", 32'(busy), 32'h0);
    check("midrst.owner", 32'(owner), 32'd3);
    req = '0;
    step(); check_all("midrst.held");
    rst = 1'b0;
    step(); check_all("midrst.after");

    // All requesting continuously: order 0,1,2,3,0,1,2,3, grants 4 cycles apart.
    wdata = 32'h13121110;
    req = 4'b1111;
    n_ack = 0; last_rise = -1; prev_grant = '0;
    for (int c = 0; c < 40 && n_ack < 8; c++) begin
      step(); check_all("all");
      if (grant != 0 && prev_grant == 0) begin
        if (last_rise >= 0) check("all.spacing", 32'(c - last_rise), 32'd4);
        last_rise = c;
      end
      prev_grant = grant;
      if (ack != 0) begin
        check("all.order", 32'(onehot_idx(ack)), 32'(order8[n_ack]));
        check("all.q_lane", 32'(q), 32'h10 + 32'(order8[n_ack]));
        n_ack++;
      end
    end
    check("all.count", 32'(n_ack), 32'd8);

    // Wrap after winner 3: req=1001 -> 0 then 3.
    req = 4'b1001;
    n_ack = 0;
    for (int c = 0; c < 16 && n_ack < 2; c++) begin
      step(); check_all("wrap");
      if (ack != 0) begin
        check("wrap.order", 32'(onehot_idx(ack)), 32'(order2[n_ack]));
        req[onehot_idx(ack)] = 1'b0;
        n_ack++;
      end
    end
    check("wrap.count", 32'(n_ack), 32'd2);
    t = 0;
    while (busy && t < 8) begin step(); check_all("wrap.drain"); t++; end
    check("wrap.idle", 32'(busy), 32'h0);

    // Request dropped right after grant: write still completes.
    wdata[7:0] = 8'h5C;
    req = 4'b0001;
    step(); check_all("drop.grant"); check("drop.grant_v", 32'(grant), 32'h1);
    req = '0;
    step(); check_all("drop.ack");
    check("drop.ack_v", 32'(ack), 32'h1); check("drop.q", 32'(q), 32'h5C);
    step(); check_all("drop.hold");
    step(); check_all("drop.idle");

    // Random traffic: each requester holds its request until its own ack.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
      wdata = $urandom();
      step(); check_all("rand");
      if (m_age == 2) req[m_owner] = 1'b0;
    end
    req = '0;

    // HOLD_CYC=0 instance: requester 1 held, grants every 3 cycles, q loads only on ack.
    qz_exp = 8'h00;
    req_z = 4'b0010;
    for (int i = 0; i < 12; i++) begin
      wdata_z[15:8] = 8'h40 + 8'(i);
      if (i % 3 == 1) qz_exp = 8'h40 + 8'(i);
      step();
      check("h0.grant", 32'(grant_z), (i % 3 != 2) ? 32'h2 : 32'h0);
      check("h0.ack",   32'(ack_z),   (i % 3 == 1) ? 32'h2 : 32'h0);
      check("h0.q",     32'(q_z),     32'(qz_exp));
      check("h0.owner", 32'(owner_z), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
